// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard detection / forwarding unit.
package hazard_pkg;

  localparam int RD_W     = 8;
  localparam int FWD_NONE = 0;

  // One in-flight producer; rd is zero-extended from REG_W so the type is parameter-free.
  typedef struct packed {
    logic            vld;
    logic            wr;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } slot_t;

  function automatic int fs_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request fields in, stall / forward-select / stall counter out.
interface hazard_ctrl_if #(
  parameter int REG_W = 3,
  parameter int FS_W  = 2
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_vld;
  logic             id_rt_vld;
  logic             id_wr;
  logic [REG_W-1:0] id_rd;
  logic             id_is_load;
  logic             flush;
  logic             stall;
  logic [FS_W-1:0]  fwd_rs;
  logic [FS_W-1:0]  fwd_rt;
  logic [15:0]      stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_vld, id_rt_vld, id_wr, id_rd, id_is_load, flush,
    input  stall, fwd_rs, fwd_rt, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_vld, id_rt_vld, id_wr, id_rd, id_is_load, flush,
    output stall, fwd_rs, fwd_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// Compares one in-flight producer slot against both ID source operands.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  slot_t            i_slot,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_rs_vld,
  input  logic             i_rt_vld,
  output logic             match_rs,
  output logic             match_rt
);
  logic w_wr_hit;
  logic w_unused_ld;

  // R0 is an ordinary register here, so no zero-index exclusion.
  assign w_wr_hit    = i_slot.vld & i_slot.wr;
  assign match_rs    = w_wr_hit & i_rs_vld & (i_slot.rd == RD_W'(i_rs));
  assign match_rt    = w_wr_hit & i_rt_vld & (i_slot.rd == RD_W'(i_rt));
  assign w_unused_ld = i_slot.is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Tracks DEPTH in-flight producers after ID and derives stall / forward selects.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int DEPTH    = 2,
  parameter int FWD_EN   = 1,
  parameter int FS_W     = fs_width(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);
  slot_t [DEPTH-1:0] r_slot;
  slot_t             w_id_slot;
  logic [DEPTH-1:0]  w_m_rs;
  logic [DEPTH-1:0]  w_m_rt;
  logic              w_live;
  logic              w_load_use;
  logic              w_any_hit;
  logic              w_stall;
  logic [FS_W-1:0]   w_sel_rs;
  logic [FS_W-1:0]   w_sel_rt;
  logic [15:0]       r_stall_cnt;

  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    hazard_match #(.REG_W(REG_W)) u_match (
      .i_slot   (r_slot[k]),
      .i_rs     (bus.id_rs),
      .i_rt     (bus.id_rt),
      .i_rs_vld (bus.id_rs_vld),
      .i_rt_vld (bus.id_rt_vld),
      .match_rs (w_m_rs[k]),
      .match_rt (w_m_rt[k])
    );
  end

  // flush kills the ID instruction, so it can neither stall nor forward.
  assign w_live     = bus.id_valid & ~bus.flush;
  assign w_load_use = r_slot[0].is_load & (w_m_rs[0] | w_m_rt[0]);
  assign w_any_hit  = |(w_m_rs | w_m_rt);
  assign w_stall    = w_live & ((FWD_EN != 0) ? w_load_use : w_any_hit);

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_sel_rs = FS_W'(FWD_NONE);
    w_sel_rt = FS_W'(FWD_NONE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_m_rs[k]) w_sel_rs = FS_W'(k + 1);
      if (w_m_rt[k]) w_sel_rt = FS_W'(k + 1);
    end
  end

  assign bus.stall     = w_stall;
  assign bus.fwd_rs    = (FWD_EN != 0 && w_live && !w_stall) ? w_sel_rs : '0;
  assign bus.fwd_rt    = (FWD_EN != 0 && w_live && !w_stall) ? w_sel_rt : '0;
  assign bus.stall_cnt = r_stall_cnt;

  always_comb begin
    w_id_slot         = '0;
    w_id_slot.vld     = 1'b1;
    w_id_slot.wr      = bus.id_wr;
    w_id_slot.rd      = RD_W'(bus.id_rd);
    w_id_slot.is_load = bus.id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else begin
      r_slot[0] <= (w_live && !w_stall) ? w_id_slot : slot_t'('0);
      for (int k = 1; k < DEPTH; k++) r_slot[k] <= r_slot[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: forwarding, stall-only and deep stall-only instances share one ID stimulus.
module tb_hazard_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(3), .FS_W(2)) bf ();
  hazard_ctrl_if #(.REG_W(3), .FS_W(2)) bs ();
  hazard_ctrl_if #(.REG_W(3), .FS_W(3)) bsat ();

  assign bs.id_valid   = bf.id_valid;    assign bsat.id_valid   = bf.id_valid;
  assign bs.id_rs      = bf.id_rs;       assign bsat.id_rs      = bf.id_rs;
  assign bs.id_rt      = bf.id_rt;       assign bsat.id_rt      = bf.id_rt;
  assign bs.id_rs_vld  = bf.id_rs_vld;   assign bsat.id_rs_vld  = bf.id_rs_vld;
  assign bs.id_rt_vld  = bf.id_rt_vld;   assign bsat.id_rt_vld  = bf.id_rt_vld;
  assign bs.id_wr      = bf.id_wr;       assign bsat.id_wr      = bf.id_wr;
  assign bs.id_rd      = bf.id_rd;       assign bsat.id_rd      = bf.id_rd;
  assign bs.id_is_load = bf.id_is_load;  assign bsat.id_is_load = bf.id_is_load;
  assign bs.flush      = bf.flush;       assign bsat.flush      = bf.flush;

  hazard_ctrl #(.DEPTH(2), .FWD_EN(1)) u_fwd (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
  hazard_ctrl #(.DEPTH(2), .FWD_EN(0)) u_stl (.clk(clk), .rst_n(rst_n), .bus(bs.slave));
  hazard_ctrl #(.DEPTH(4), .FWD_EN(0)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bsat.slave));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   exp_cnt;

  task automatic push(input string tag, input logic [31:0] val);
    sbq.push_back('{tag, val});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_tot++;
    if (sbq.size() == 0) begin
      $error("FAIL scoreboard: got %0d with no expectation pending", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic idrv(input int v, input int rs, input int rsv, input int rt, input int rtv,
                      input int wr, input int rd, input int ld, input int fl);
    bf.id_valid   = v[0];
    bf.id_rs      = rs[2:0];
    bf.id_rs_vld  = rsv[0];
    bf.id_rt      = rt[2:0];
    bf.id_rt_vld  = rtv[0];
    bf.id_wr      = wr[0];
    bf.id_rd      = rd[2:0];
    bf.id_is_load = ld[0];
    bf.flush      = fl[0];
  endtask

  initial begin
    // reset: ID reads r0 but nothing is in flight
    idrv(1, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    push("rst_stall", 0); push("rst_fwd_rs", 0); push("rst_fwd_rt", 0);
    push("rst_cnt", 0);   push("rst_sat_fwd", 0);
    chk(bf.stall); chk(bf.fwd_rs); chk(bf.fwd_rt); chk(bf.stall_cnt); chk(bsat.fwd_rs);
    rst_n = 1'b1;
    #1; push("empty_fwd", 0); push("empty_stl_stall", 0);
    chk(bf.fwd_rs); chk(bs.stall);
    @(negedge clk);

    // ADD r3, then read r3
    idrv(1, 0, 0, 0, 0, 1, 3, 0, 0);
    #1; push("add_stall", 0); chk(bf.stall);
    @(negedge clk);
    idrv(1, 3, 1, 0, 0, 0, 0, 0, 0);
    #1; push("alu_fwd_stall", 0); push("alu_fwd_rs", 1); push("alu_stl_stall", 1); push("stl_fwd_rs", 0);
    chk(bf.stall); chk(bf.fwd_rs); chk(bs.stall); chk(bs.fwd_rs);
    @(negedge clk);
    #1; push("alu_fwd_rs_s1", 2); push("alu_stl_stall2", 1);
    chk(bf.fwd_rs); chk(bs.stall);
    @(negedge clk);
    #1; push("alu_stl_release", 0); chk(bs.stall);
    @(negedge clk);

    // write r5, unrelated write r1, then read r5
    idrv(1, 0, 0, 0, 0, 1, 5, 0, 0);
    @(negedge clk);
    idrv(1, 6, 1, 0, 0, 1, 1, 0, 0);
    #1; push("unrel_stall", 0); chk(bs.stall);
    @(negedge clk);
    idrv(1, 0, 0, 5, 1, 0, 0, 0, 0);
    #1; push("s1_stl_stall", 1); push("s1_fwd_rt", 2);
    chk(bs.stall); chk(bf.fwd_rt);
    @(negedge clk);
    #1; push("s1_stl_once", 0); push("stl_cnt3", 3); push("s1_fwd_gone", 0);
    chk(bs.stall); chk(bs.stall_cnt); chk(bf.fwd_rt);
    @(negedge clk);

    // load-use: LD r2 then read rt=r2 (rs=r2 not read)
    idrv(1, 0, 0, 0, 0, 1, 2, 1, 0);
    #1; push("ld_issue_stall", 0); chk(bf.stall);
    @(negedge clk);
    idrv(1, 2, 0, 2, 1, 0, 0, 0, 0);
    #1; push("lu_stall", 1); push("lu_fwd_rt", 0); push("lu_fwd_rs", 0); push("lu_cnt0", 0);
    chk(bf.stall); chk(bf.fwd_rt); chk(bf.fwd_rs); chk(bf.stall_cnt);
    @(negedge clk);
    #1; push("lu_release", 0); push("lu_fwd_rt2", 2); push("lu_rs_unread", 0); push("lu_cnt1", 1);
    chk(bf.stall); chk(bf.fwd_rt); chk(bf.fwd_rs); chk(bf.stall_cnt);
    @(negedge clk);

    // load-use coinciding with flush
    idrv(1, 0, 0, 0, 0, 1, 7, 1, 0);
    @(negedge clk);
    idrv(1, 7, 1, 0, 0, 0, 0, 0, 1);
    #1; push("fl_stall", 0); push("fl_fwd", 0); push("fl_stl_stall", 0);
    chk(bf.stall); chk(bf.fwd_rs); chk(bs.stall);
    @(negedge clk);
    idrv(1, 7, 1, 0, 0, 0, 0, 0, 0);
    #1; push("fl_bubble_stall", 0); push("fl_shift_fwd", 2); push("fl_cnt", 1);
    chk(bf.stall); chk(bf.fwd_rs); chk(bf.stall_cnt);
    @(negedge clk);

    // both slots write r4: youngest wins
    idrv(1, 0, 0, 0, 0, 1, 4, 0, 0);
    repeat (2) @(negedge clk);
    idrv(1, 4, 1, 4, 1, 0, 0, 0, 0);
    #1; push("young_rs", 1); push("young_rt", 1); push("young_stall", 0);
    chk(bf.fwd_rs); chk(bf.fwd_rt); chk(bf.stall);
    @(negedge clk);

    // R0 is matched like any register
    idrv(1, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    idrv(1, 0, 1, 0, 0, 0, 0, 0, 0);
    #1; push("r0_fwd", 1); push("r0_stl_stall", 1);
    chk(bf.fwd_rs); chk(bs.stall);
    @(negedge clk);
    idrv(0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1; push("inv_fwd", 0); push("inv_stall", 0); push("inv_stl_stall", 0);
    chk(bf.fwd_rs); chk(bf.stall); chk(bs.stall);
    repeat (4) @(negedge clk);

    // deep stall-only instance: reset in the middle of a stall
    idrv(1, 1, 1, 0, 0, 1, 1, 0, 0);
    #1; push("sat_first", 0); chk(bsat.stall);
    @(negedge clk);
    #1; push("sat_mid_stall", 1); chk(bsat.stall);
    rst_n = 1'b0;
    #1; push("rst_mid_stall", 0); push("rst_mid_cnt", 0); push("rst_mid_fwd", 0); push("rst_mid_fcnt", 0);
    chk(bsat.stall); chk(bsat.stall_cnt); chk(bsat.fwd_rs); chk(bf.stall_cnt);
    @(negedge clk);
    rst_n = 1'b1;

    // same write-r1/read-r1 instruction: 4 stall cycles out of every 5
    exp_cnt = 0;
    for (int c = 0; c < 82500; c++) begin
      #1;
      if (c < 12 || c == 500) begin
        push($sformatf("sat_stall_c%0d", c), ((c % 5) != 0) ? 1 : 0);
        chk(bsat.stall);
      end
      if (c == 500) begin
        push("sat_cnt_500", exp_cnt);
        chk(bsat.stall_cnt);
      end
      if ((c % 5) != 0 && exp_cnt != 'hFFFF) exp_cnt++;
      @(negedge clk);
    end
    #1; push("sat_cnt_hold", exp_cnt); chk(bsat.stall_cnt);
    @(negedge clk);
    #1; push("sat_end_stall", 1); push("sat_end_cnt", 'hFFFF);
    chk(bsat.stall); chk(bsat.stall_cnt);
    rst_n = 1'b0;
    #1; push("sat_rst_cnt", 0); push("sat_rst_slots", 0); push("stl_rst_cnt", 0);
    chk(bsat.stall_cnt); chk(bsat.stall); chk(bs.stall_cnt);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_REGS, default 8: architectural register count.
REQ-003 Parameter REG_W, default 3: register index width, equal to clog2(NUM_REGS).
REQ-004 Parameter DEPTH, default 2: number of in-flight producer slots tracked after ID (1..4).
REQ-005 Parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-006 Parameter FS_W, default 2: forward-select width, equal to clog2(DEPTH+1).
REQ-007 clk  in  1  clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 id_valid  in  1  ID holds a real instruction.
REQ-010 id_rs, id_rt  in  REG_W each  source indices.
REQ-011 id_rs_vld, id_rt_vld  in  1 each  source is actually read.
REQ-012 id_wr, id_rd  in  1 / REG_W  ID instruction writes register id_rd.
REQ-013 id_is_load  in  1  ID instruction is a memory load.
REQ-014 flush  in  1  branch/jump redirect; kill the ID instruction.
REQ-015 stall  out  1  hold PC and IF/ID; inject bubble into ID/EX.
REQ-016 fwd_rs, fwd_rt  out  FS_W each  0 = register file, k = result of slot k-1.
REQ-017 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-018 The block SHALL keep a DEPTH-entry shift register; each entry holds {vld, wr, rd, is_load}; slot 0 is the instruction in EX.
REQ-019 Every clock edge SHALL shift slot k into slot k+1, dropping the last slot.
REQ-020 Slot 0 SHALL load the ID fields when id_valid=1, stall=0 and flush=0; otherwise it SHALL load a bubble (vld=0).
REQ-021 Slot k SHALL match source s when vld=1, wr=1, rd=s and the source's _vld bit is 1; R0 is an ordinary register and is matched.
REQ-022 With FWD_EN=0, stall SHALL be 1 when id_valid=1, flush=0 and any slot matches id_rs or id_rt.
REQ-023 With FWD_EN=0, fwd_rs and fwd_rt SHALL be 0.
REQ-024 With FWD_EN=1, stall SHALL be 1 only when id_valid=1, flush=0, and slot 0 has is_load=1 and matches a source (load-use).
REQ-025 With FWD_EN=1, fwd_x SHALL be k+1 for the lowest-numbered (youngest) matching slot k, and 0 when no slot matches.
REQ-026 With FWD_EN=1 and stall=1, fwd outputs SHALL be 0.
REQ-027 stall and fwd outputs SHALL be combinational from slot state and ID inputs, with zero-cycle latency.
REQ-028 A load-use hazard SHALL produce exactly one stall cycle; the next cycle SHALL forward from slot 1 (fwd=2).
REQ-029 flush SHALL override stall (stall=0) and insert a bubble; existing slots still shift.
REQ-030 stall_cnt SHALL increment on each edge where stall=1.
REQ-031 stall_cnt SHALL hold at 16'hFFFF once reached (no wrap).
REQ-032 id_valid=0 SHALL force stall=0 and fwd=0.

Reset
REQ-033 rst_n=0 SHALL asynchronously clear every slot to vld=0 and stall_cnt to 0.
REQ-034 While rst_n=0, stall SHALL be 0 and fwd_rs and fwd_rt SHALL be 0.
REQ-035 Reset asserted mid-stall SHALL discard all pending hazards.
REQ-036 After reset release, the first cycle SHALL see an empty pipeline.

Structure
REQ-037 Package hazard_pkg SHALL hold the slot entry typedef, the FWD_NONE=0 constant, and the FS_W derivation function.
REQ-038 Sub-module hazard_match SHALL be instantiated per slot; it compares one slot against id_rs/id_rt and outputs match_rs and match_rt.
REQ-039 Priority encoding and the counter SHALL reside in hazard_ctrl.

Verification
REQ-040 FWD_EN=1: ADD r3 in slot 0, then ID reads rs=r3 -> stall=0, fwd_rs=1.
REQ-041 FWD_EN=1: LD r2 in slot 0, ID reads rt=r2 with rt_vld=1 -> stall=1 for one cycle; next cycle fwd_rt=2; stall_cnt=1.
REQ-042 FWD_EN=0, DEPTH=2: write r5 then an unrelated instruction, then ID reads r5 -> stall=1 for exactly 1 cycle (r5 in slot 1), then 0.
REQ-043 Load-use condition with flush=1 in the same cycle -> stall=0 and a bubble enters slot 0.
REQ-044 Both slots write r4, ID reads r4 -> fwd_rs=1 (youngest wins).
REQ-045 Force stall for 70000 cycles -> stall_cnt=16'hFFFF; then drive rst_n=0 asynchronously -> stall_cnt=0 and all slots invalid without a clock edge.
